// File: rtl/serial_bus_arbiter_if.sv
// Requester-side and transceiver-side signals of the serial bus arbiter.
// The arbiter uses the master view; the requesters and transceiver model use slave.
interface serial_bus_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [31:0] tx_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [7:0]  rx_data;
    logic        bus_tEN;
    logic        bus_rEN;
    logic [7:0]  bus_tDP;
    logic        bus_tDONE;
    logic        bus_rDONE;
    logic [7:0]  bus_rDP;
    logic [15:0] bus_cycle;

    modport master (
        input  req, dir, tx_data, bus_tDONE, bus_rDONE, bus_rDP,
        output gnt, done, err, rx_data, bus_tEN, bus_rEN, bus_tDP, bus_cycle
    );

    modport slave (
        output req, dir, tx_data, bus_tDONE, bus_rDONE, bus_rDP,
        input  gnt, done, err, rx_data, bus_tEN, bus_rEN, bus_tDP, bus_cycle
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter granting four requesters one at a time onto a shared
// serial transceiver, with start strobes, completion-edge detection and timeout.
//
// state | meaning
// IDLE  | waiting for any request; picks next requester from ptr upward
// GRANT | grant held; direction and transmit byte captured
// START | one-cycle tEN or rEN strobe to the transceiver
// WAIT  | watching the selected DONE level for a fresh 0->1 edge, or timeout
// FIN   | done pulse to the granted requester; grant released afterwards
module serial_bus_arbiter #(
    parameter int          CYCLE   = 16,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_bus_arbiter_if.master  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GRANT = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam logic [15:0] TOUT_LAST = TIMEOUT - 16'd1;

    logic [2:0]  state;
    logic [1:0]  ptr;
    logic [1:0]  sel;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        curDir;
    logic        doneQ;
    logic        doneLvl;
    logic        doneEdge;
    logic        toutHit;
    logic [15:0] toutCnt;

    assign bus.bus_cycle = 16'(CYCLE);

    // Scan from the highest rotated offset down so the nearest request to ptr wins.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req[idx]) begin
                pick = idx;
            end
        end
    end

    assign doneLvl  = curDir ? bus.bus_tDONE : bus.bus_rDONE;
    assign doneEdge = doneLvl & ~doneQ;
    // Counter holds the number of WAIT cycles already spent; the next one reaches TIMEOUT.
    assign toutHit  = (toutCnt == TOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            sel         <= 2'd0;
            curDir      <= 1'b0;
            doneQ       <= 1'b0;
            toutCnt     <= 16'd0;
            bus.gnt     <= 4'd0;
            bus.done    <= 4'd0;
            bus.err     <= 4'd0;
            bus.rx_data <= 8'h00;
            bus.bus_tEN <= 1'b0;
            bus.bus_rEN <= 1'b0;
            bus.bus_tDP <= 8'h00;
        end else begin
            bus.done    <= 4'd0;
            bus.err     <= 4'd0;
            bus.bus_tEN <= 1'b0;
            bus.bus_rEN <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        sel     <= pick;
                        bus.gnt <= 4'b0001 << pick;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    curDir      <= bus.dir[sel];
                    bus.bus_tDP <= bus.tx_data[{sel, 3'b000} +: 8];
                    bus.bus_tEN <= bus.dir[sel];
                    bus.bus_rEN <= ~bus.dir[sel];
                    toutCnt     <= 16'd0;
                    state       <= START;
                end
                START: begin
                    // Seed the edge detector so a DONE already high on entry is not a completion.
                    doneQ <= doneLvl;
                    state <= WAIT;
                end
                WAIT: begin
                    doneQ <= doneLvl;
                    if (doneEdge) begin
                        // Received byte is registered alongside done so both are valid in FIN.
                        if (!curDir) begin
                            bus.rx_data <= bus.bus_rDP;
                        end
                        bus.done <= bus.gnt;
                        state    <= FIN;
                    end else if (toutHit) begin
                        bus.err <= bus.gnt;
                        bus.gnt <= 4'd0;
                        ptr     <= sel + 2'd1;
                        state   <= IDLE;
                    end else begin
                        toutCnt <= toutCnt + 16'd1;
                    end
                end
                FIN: begin
                    bus.gnt <= 4'd0;
                    ptr     <= sel + 2'd1;
                    state   <= IDLE;
                end
                default: begin
                    bus.gnt <= 4'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) $onehot0(bus.gnt));
    assert property (@(posedge clk) !((|bus.done) && (|bus.err)));
    assert property (@(posedge clk) !(bus.bus_tEN && bus.bus_rEN));

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Randomized self-checking bench for serial_bus_arbiter; expectations come from a
// transaction-level model (round-robin pointer, fixed latencies, last received byte).
module tb_serial_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int ptrM = 0;
    logic [7:0] rxM = 8'h00;
    int noiseMode = 0;

    serial_bus_arbiter_if bus();

    serial_bus_arbiter #(.CYCLE(16), .TIMEOUT(16'd8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    // The DONE line of the direction not in use is jittered to prove it is ignored.
    task automatic step();
        @(posedge clk);
        #1;
        if (noiseMode == 1) bus.bus_rDONE = 1'($urandom_range(0, 1));
        else if (noiseMode == 2) bus.bus_tDONE = 1'($urandom_range(0, 1));
    endtask

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    // Drives a request and follows it through GRANT and START to the first WAIT cycle.
    task automatic start_txn(input logic [3:0] reqV, input logic [3:0] dirV, input logic [31:0] txV,
                             input bit stale, input bit hold, output int sel, output bit isTx);
        logic [3:0] exp;
        logic [7:0] txB;
        sel  = model_pick(reqV, ptrM);
        exp  = 4'b0001 << sel;
        isTx = dirV[sel];
        txB  = txV[8*sel +: 8];
        bus.req = reqV;
        bus.dir = dirV;
        bus.tx_data = txV;
        bus.bus_tDONE = stale & isTx;
        bus.bus_rDONE = stale & ~isTx;
        noiseMode = 0;
        step();
        checks++;
        if (bus.gnt !== exp) begin
            failures++;
            $display("FAIL grant: got %b want %b", bus.gnt, exp);
        end
        checks++;
        if ({bus.bus_tEN, bus.bus_rEN, bus.done, bus.err} !== 10'b0) begin
            failures++;
            $display("FAIL grant_quiet: got tEN=%b rEN=%b done=%b err=%b want all 0",
                     bus.bus_tEN, bus.bus_rEN, bus.done, bus.err);
        end
        step();
        checks++;
        if ({bus.bus_tEN, bus.bus_rEN} !== {isTx, ~isTx}) begin
            failures++;
            $display("FAIL start_strobe: got tEN=%b rEN=%b want tEN=%b rEN=%b",
                     bus.bus_tEN, bus.bus_rEN, isTx, ~isTx);
        end
        checks++;
        if (bus.bus_tDP !== txB) begin
            failures++;
            $display("FAIL tdp: got %h want %h", bus.bus_tDP, txB);
        end
        checks++;
        if (bus.gnt !== exp) begin
            failures++;
            $display("FAIL grant_hold_start: got %b want %b", bus.gnt, exp);
        end
        bus.dir = 4'($urandom);
        bus.tx_data = $urandom;
        if (!hold) bus.req = 4'b0000;
        noiseMode = isTx ? 1 : 2;
        step();
        checks++;
        if ({bus.bus_tEN, bus.bus_rEN} !== 2'b00 || bus.gnt !== exp) begin
            failures++;
            $display("FAIL strobe_width: got tEN=%b rEN=%b gnt=%b want 0 0 %b",
                     bus.bus_tEN, bus.bus_rEN, bus.gnt, exp);
        end
    endtask

    task automatic do_txn(input logic [3:0] reqV, input logic [3:0] dirV, input logic [31:0] txV,
                          input int delay, input logic [7:0] rxB, input bit hold, input bit stale);
        int sel;
        bit isTx;
        logic [3:0] exp;
        logic [7:0] rxExp;
        int d;
        start_txn(reqV, dirV, txV, stale, hold, sel, isTx);
        exp = 4'b0001 << sel;
        bus.bus_rDP = rxB;
        d = delay;
        if (stale) begin
            step();
            checks++;
            if (bus.done !== 4'b0) begin
                failures++;
                $display("FAIL stale_done: got done=%b want 0000", bus.done);
            end
            if (isTx) bus.bus_tDONE = 1'b0;
            else bus.bus_rDONE = 1'b0;
            if (d == 0) d = 1;
        end
        repeat (d) begin
            step();
            checks++;
            if (bus.done !== 4'b0 || bus.err !== 4'b0 || bus.gnt !== exp) begin
                failures++;
                $display("FAIL wait_hold: got done=%b err=%b gnt=%b want 0000 0000 %b",
                         bus.done, bus.err, bus.gnt, exp);
            end
        end
        if (isTx) bus.bus_tDONE = 1'b1;
        else bus.bus_rDONE = 1'b1;
        step();
        checks++;
        if (bus.done !== exp || bus.err !== 4'b0) begin
            failures++;
            $display("FAIL done_pulse: got done=%b err=%b want %b 0000", bus.done, bus.err, exp);
        end
        rxExp = isTx ? rxM : rxB;
        checks++;
        if (bus.rx_data !== rxExp) begin
            failures++;
            $display("FAIL rx_data: got %h want %h", bus.rx_data, rxExp);
        end
        rxM = rxExp;
        noiseMode = 0;
        bus.bus_tDONE = 1'b0;
        bus.bus_rDONE = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.rx_data !== rxM) begin
            failures++;
            $display("FAIL release: got gnt=%b done=%b rx=%h want 0000 0000 %h",
                     bus.gnt, bus.done, bus.rx_data, rxM);
        end
        bus.bus_rDP = 8'($urandom);
        ptrM = (sel + 1) % 4;
    endtask

    task automatic test_reset();
        bus.req = 4'b0;
        bus.dir = 4'b0;
        bus.tx_data = 32'h0;
        bus.bus_tDONE = 1'b0;
        bus.bus_rDONE = 1'b0;
        bus.bus_rDP = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.gnt, bus.done, bus.err} !== 12'b0) begin
            failures++;
            $display("FAIL reset_flags: got gnt=%b done=%b err=%b want 0", bus.gnt, bus.done, bus.err);
        end
        checks++;
        if (bus.rx_data !== 8'h00 || bus.bus_tDP !== 8'h00 || {bus.bus_tEN, bus.bus_rEN} !== 2'b00) begin
            failures++;
            $display("FAIL reset_data: got rx=%h tdp=%h tEN=%b rEN=%b want 00 00 0 0",
                     bus.rx_data, bus.bus_tDP, bus.bus_tEN, bus.bus_rEN);
        end
        checks++;
        if (bus.bus_cycle !== 16'd16) begin
            failures++;
            $display("FAIL bus_cycle: got %0d want 16", bus.bus_cycle);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.gnt !== 4'b0) begin
            failures++;
            $display("FAIL idle_no_req: got gnt=%b want 0000", bus.gnt);
        end
        ptrM = 0;
        rxM = 8'h00;
    endtask

    task automatic test_single_tx();
        do_txn(4'b0001, 4'b0001, 32'h0000_00A5, 2, 8'h77, 1'b0, 1'b0);
    endtask

    task automatic test_single_rx();
        do_txn(4'b0100, 4'b1011, 32'h1122_3344, 3, 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ptrM = 0;
        rxM = 8'h00;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 4'($urandom), $urandom, $urandom_range(0, 3), 8'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic test_timeout();
        int sel;
        bit isTx;
        bit stale;
        logic [3:0] exp;
        stale = 1'($urandom_range(0, 1));
        start_txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom, stale, 1'b0, sel, isTx);
        exp = 4'b0001 << sel;
        repeat (7) begin
            step();
            checks++;
            if (bus.err !== 4'b0 || bus.done !== 4'b0 || bus.gnt !== exp) begin
                failures++;
                $display("FAIL timeout_early: got err=%b done=%b gnt=%b want 0000 0000 %b",
                         bus.err, bus.done, bus.gnt, exp);
            end
        end
        step();
        checks++;
        if (bus.err !== exp) begin
            failures++;
            $display("FAIL timeout_err: got err=%b want %b", bus.err, exp);
        end
        checks++;
        if (bus.gnt !== 4'b0 || bus.done !== 4'b0) begin
            failures++;
            $display("FAIL timeout_release: got gnt=%b done=%b want 0000 0000", bus.gnt, bus.done);
        end
        noiseMode = 0;
        bus.bus_tDONE = 1'b0;
        bus.bus_rDONE = 1'b0;
        step();
        checks++;
        if (bus.err !== 4'b0) begin
            failures++;
            $display("FAIL timeout_width: got err=%b want 0000", bus.err);
        end
        ptrM = (sel + 1) % 4;
        do_txn(4'b1111, 4'($urandom), $urandom, 1, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_stale_done();
        do_txn(4'b0010, 4'b0010, 32'h0000_5500, 2, 8'h00, 1'b0, 1'b1);
        do_txn(4'b1000, 4'b0000, 32'h0, 1, 8'hC3, 1'b0, 1'b1);
    endtask

    task automatic test_reset_in_wait();
        int sel;
        bit isTx;
        do_txn(4'b0001, 4'b0000, 32'h0, 1, 8'h5A, 1'b0, 1'b0);
        start_txn(4'b1111, 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b1, sel, isTx);
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus.gnt, bus.done, bus.err} !== 12'b0) begin
            failures++;
            $display("FAIL wait_reset_flags: got gnt=%b done=%b err=%b want 0", bus.gnt, bus.done, bus.err);
        end
        checks++;
        if (bus.rx_data !== 8'h00 || bus.bus_tDP !== 8'h00 || {bus.bus_tEN, bus.bus_rEN} !== 2'b00) begin
            failures++;
            $display("FAIL wait_reset_data: got rx=%h tdp=%h tEN=%b rEN=%b want 00 00 0 0",
                     bus.rx_data, bus.bus_tDP, bus.bus_tEN, bus.bus_rEN);
        end
        rst_n = 1'b1;
        noiseMode = 0;
        bus.bus_tDONE = 1'b0;
        bus.bus_rDONE = 1'b0;
        ptrM = 0;
        rxM = 8'h00;
        do_txn(4'b1111, 4'($urandom), $urandom, 2, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom, $urandom_range(0, 4),
                   8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_single_rx();
        test_round_robin();
        test_timeout();
        test_stale_done();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_bus_arbiter.md
SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on posedge clk.
REQ-002 Parameter CYCLE, default 16: bit period in clocks, driven unchanged on bus_cycle.
REQ-003 Parameter TIMEOUT, default 1024: clocks allowed in WAIT before abort; 16-bit.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req  in  4  per-requester request level; bit i = requester i.
REQ-007 dir  in  4  per-requester direction; 1 = transmit, 0 = receive.
REQ-008 tx_data  in  32  requester i transmit byte at [8i+7:8i].
REQ-009 gnt  out  4  one-hot grant, held for the whole transaction.
REQ-010 done  out  4  one-cycle completion pulse to the granted requester.
REQ-011 err  out  4  one-cycle timeout pulse to the granted requester.
REQ-012 rx_data  out  8  last received byte; valid when done pulses on a receive.
REQ-013 bus_tEN, bus_rEN  out  1 each  transceiver start strobes.
REQ-014 bus_tDP  out  8  byte to transmit.
REQ-015 bus_tDONE, bus_rDONE  in  1 each  transceiver completion levels.
REQ-016 bus_cycle  out  16  equals CYCLE.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, START, WAIT, FIN.
REQ-018 IDLE: if req != 0, pick the first set bit searching from ptr upward with wrap 3->0; go to GRANT next cycle. Else stay.
REQ-019 GRANT: assert gnt[sel]; latch dir[sel] into cur_dir; latch tx_data[sel] into bus_tDP; clear timeout counter.
REQ-020 START: exactly one cycle of bus_tEN=1 if cur_dir=1, else bus_rEN=1; never both.
REQ-021 WAIT: sample the selected DONE level (bus_tDONE for transmit, bus_rDONE for receive) into a registered copy. A 0->1 transition between consecutive samples SHALL move to FIN.
REQ-022 WAIT: the timeout counter increments each cycle. On reaching TIMEOUT: pulse err[sel] one cycle, drop gnt, go to IDLE.
REQ-023 FIN, receive: capture the transceiver receive byte into rx_data. FIN, transmit: rx_data unchanged.
REQ-024 FIN: pulse done[sel] one cycle; drop gnt; go to IDLE.
REQ-025 ptr SHALL become (sel+1) mod 4 on leaving FIN or on timeout. ptr wraps from 3 to 0.
REQ-026 Latency: req seen in IDLE at cycle N gives gnt at N+1 and the EN strobe at N+2. done arrives 1 cycle after the DONE edge is detected.
REQ-027 req deasserted after GRANT SHALL be ignored; the transaction completes.
REQ-028 Changes to dir or tx_data after GRANT SHALL have no effect.
REQ-029 A requester holding req after done SHALL be eligible again only in ptr order, so it cannot starve others.
REQ-030 DONE already high when WAIT is entered SHALL NOT count as completion; a fresh 0->1 edge is required.
REQ-031 gnt SHALL be zero or one-hot at all times. done and err SHALL never pulse in the same cycle.

Reset
REQ-032 While rst_n=0 at posedge clk: state=IDLE, ptr=0, gnt=0, done=0, err=0, rx_data=0x00, bus_tEN=0, bus_rEN=0, bus_tDP=0x00, timeout counter=0.
REQ-033 Reset mid-transaction SHALL abort immediately with no done or err pulse. The first post-reset arbitration starts from requester 0.

Verification
REQ-034 Single TX: req=0001, dir=0001, tx_data[7:0]=0xA5 -> gnt=0001 one cycle later; bus_tEN pulses 1 cycle with bus_tDP=0xA5; after a model tDONE edge, done=0001 for 1 cycle.
REQ-035 Single RX: req=0100, dir=0 on bit 2, model returns 0x3C -> bus_rEN pulse only; rx_data=0x3C with done=0100.
REQ-036 All four requesting continuously from reset -> grant order 0,1,2,3,0; each gnt one-hot; no overlap between gnt periods.
REQ-037 Timeout: with TIMEOUT=8 and DONE never rising -> err pulses 8 cycles after WAIT entry; no done pulse; ptr advances to the next requester.
REQ-038 Stale DONE: tDONE held high before START -> no completion until tDONE falls and rises again.
REQ-039 Reset in WAIT: rst_n low 1 cycle -> all outputs at reset values; no done or err pulse; next grant goes to the lowest requesting index.
